// File: rtl/instr_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_wr_arbiter
// Description : Round-robin write-port arbiter and write-address sequencer
//               feeding the instruction register (grant, capture, pointer,
//               occupancy, wrap/full handling).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 32,
    parameter int WRAP_EN = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][3:0]         req_opcode,
    input  logic [NUM_REQ-1:0][31:0]        req_operand_a,
    input  logic [NUM_REQ-1:0][31:0]        req_operand_b,
    input  logic                            flush,
    input  logic                            pause,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            load_en,
    output logic [3:0]                      opcode,
    output logic [31:0]                     operand_a,
    output logic [31:0]                     operand_b,
    output logic [$clog2(DEPTH)-1:0]        write_pointer,
    output logic [$clog2(DEPTH):0]          entries,
    output logic                            full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_idx_w = $clog2(NUM_REQ);

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_idx_w:0]   c_num_req  = (c_idx_w+1)'(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_req = c_idx_w'(NUM_REQ - 1);

    logic [c_idx_w-1:0] r_rr;
    logic [c_ptr_w-1:0] r_wp;
    logic [c_cnt_w-1:0] r_entries;
    logic               r_load_en;
    logic [3:0]         r_opcode;
    logic [31:0]        r_operand_a;
    logic [31:0]        r_operand_b;
    logic [c_ptr_w-1:0] r_write_pointer;

    logic               w_full;
    logic               w_eligible;
    logic               w_any;
    logic [c_idx_w:0]   w_cand;
    logic [c_idx_w-1:0] w_win_idx;
    logic [c_idx_w-1:0] w_rr_nxt;
    logic [NUM_REQ-1:0] w_grant;

    // Full only exists in the non-wrapping mode; it is a pure decode of the count.
    assign w_full     = (r_entries == c_depth) && (WRAP_EN == 0);
    assign w_eligible = !reset && !flush && !pause && !w_full;

    // Scan from the priority pointer; the first requesting slot wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        w_grant   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (c_idx_w+1)'(r_rr) + (c_idx_w+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (w_eligible && !w_any && req[w_cand[c_idx_w-1:0]]) begin
                w_any     = 1'b1;
                w_win_idx = w_cand[c_idx_w-1:0];
            end
        end
        if (w_any) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    assign w_rr_nxt = (w_win_idx == c_last_req) ? '0 : w_win_idx + c_idx_w'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr            <= '0;
            r_wp            <= '0;
            r_entries       <= '0;
            r_load_en       <= 1'b0;
            r_opcode        <= '0;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_write_pointer <= '0;
        end else if (flush) begin
            // Sequencing restarts; priority and last captured data are kept.
            r_wp      <= '0;
            r_entries <= '0;
            r_load_en <= 1'b0;
        end else begin
            r_load_en <= w_any;
            if (w_any) begin
                r_rr            <= w_rr_nxt;
                r_opcode        <= req_opcode[w_win_idx];
                r_operand_a     <= req_operand_a[w_win_idx];
                r_operand_b     <= req_operand_b[w_win_idx];
                r_write_pointer <= r_wp;
                r_wp            <= r_wp + c_ptr_w'(1);
                if (r_entries != c_depth) begin
                    r_entries <= r_entries + c_cnt_w'(1);
                end
            end
        end
    end

    assign grant         = w_grant;
    assign load_en       = r_load_en;
    assign opcode        = r_opcode;
    assign operand_a     = r_operand_a;
    assign operand_b     = r_operand_b;
    assign write_pointer = r_write_pointer;
    assign entries       = r_entries;
    assign full          = w_full;

endmodule
`default_nettype wire
